u2_result_fifo: RTL

Show-ahead FIFO that buffers the two's-complement result and 4-bit status produced by the combinational sign-magnitude-to-U2 converter, so that a slower consumer (output register or display stage) can drain them with a valid/ready handshake. It sits directly downstream of the converter: `cache_result` drives `i_result` and `cache_status` drives `i_status`. The converter cannot be stalled, so refused writes are flagged on a sticky overflow output rather than back-pressured.

---
 rtl/u2_pkg.sv | 8 +
 rtl/u2_result_fifo_if.sv | 32 +++
 rtl/u2_fifo_mem.sv | 25 ++
 rtl/u2_result_fifo.sv | 103 ++++++++++
 4 files changed

// File: rtl/u2_pkg.sv
// rtl/u2_pkg.sv - shared types for the sign-magnitude to U2 result path
package u2_pkg;

  localparam int STATUS_W = 4;

  typedef logic [STATUS_W-1:0] status_t;

endpackage

// File: rtl/u2_result_fifo_if.sv
// rtl/u2_result_fifo_if.sv - write/read handshake bundle of the U2 result FIFO
interface u2_result_fifo_if
  import u2_pkg::*;
#(
  parameter int K     = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          i_valid;
  logic [K-1:0]  i_result;
  status_t       i_status;
  logic          o_ready;
  logic          o_valid;
  logic          i_ready;
  logic [K-1:0]  o_result;
  status_t       o_status;
  logic [CW-1:0] o_count;
  logic          o_full;
  logic          o_empty;
  logic          o_overflow;

  modport master (
    output i_valid, i_result, i_status, i_ready,
    input  o_ready, o_valid, o_result, o_status, o_count, o_full, o_empty, o_overflow
  );

  modport slave (
    input  i_valid, i_result, i_status, i_ready,
    output o_ready, o_valid, o_result, o_status, o_count, o_full, o_empty, o_overflow
  );
endinterface

// File: rtl/u2_fifo_mem.sv
// rtl/u2_fifo_mem.sv - DEPTH x W register array, synchronous write, asynchronous read
module u2_fifo_mem #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [W-1:0]             i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [W-1:0]             o_rdata
);

  logic [W-1:0] mem [DEPTH];

  // Contents are don't-care after reset; occupancy is tracked by the top.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/u2_result_fifo.sv
// rtl/u2_result_fifo.sv - show-ahead FIFO for converter result/status with sticky overflow
// Optional same-cycle empty bypass enabled by defining U2_FIFO_BYPASS_EN.
module u2_result_fifo
  import u2_pkg::*;
#(
  parameter int K     = 8,
  parameter int DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  u2_result_fifo_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    status_t      status;
    logic [K-1:0] result;
  } u2_entry_t;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic      full, empty, bypass, wr_en, rd_en;
  u2_entry_t wr_entry, head_entry;

  always_comb begin
    full  = (count_q == CW'(DEPTH));
    empty = (count_q == '0);
`ifdef U2_FIFO_BYPASS_EN
    bypass = empty && bus.i_valid && bus.i_ready;
`else
    bypass = 1'b0;
`endif
    // Full refuses writes even if a pop happens this cycle, keeping o_ready off i_ready.
    wr_en = bus.i_valid && !full && !bypass;
    rd_en = !empty && bus.i_ready;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (bus.i_valid && full);

    if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign wr_entry.status = bus.i_status;
  assign wr_entry.result = bus.i_result;

  u2_fifo_mem #(
    .W     ($bits(u2_entry_t)),
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (wr_en),
    .i_waddr (wr_ptr_q),
    .i_wdata (wr_entry),
    .i_raddr (rd_ptr_q),
    .o_rdata (head_entry)
  );

  always_comb begin
    bus.o_ready    = !full;
    bus.o_full     = full;
    bus.o_empty    = empty;
    bus.o_count    = count_q;
    bus.o_overflow = overflow_q;
    bus.o_valid    = !empty || bypass;
    bus.o_result   = '0;
    bus.o_status   = '0;
    if (bypass) begin
      bus.o_result = bus.i_result;
      bus.o_status = bus.i_status;
    end else if (!empty) begin
      bus.o_result = head_entry.result;
      bus.o_status = head_entry.status;
    end
  end

endmodule
